// File: rtl/kyo_hit_addr_gen_if.sv
// Beam/sprite position, animation control and ROM address bus of the Kyo hit address stage.
// The facing_left signal exists only when KYO_HIT_MIRROR_EN is defined.
interface kyo_hit_addr_gen_if;
    logic        frame_start;
    logic        trigger;
    logic [9:0]  drawX;
    logic [9:0]  drawY;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
`ifdef KYO_HIT_MIRROR_EN
    logic        facing_left;
`endif
    logic [13:0] rom_address;
    logic        in_sprite;
    logic [1:0]  frame_idx;
    logic        anim_busy;

`ifdef KYO_HIT_MIRROR_EN
    modport master (output frame_start, trigger, drawX, drawY, sprite_x, sprite_y, facing_left,
                    input  rom_address, in_sprite, frame_idx, anim_busy);
    modport slave  (input  frame_start, trigger, drawX, drawY, sprite_x, sprite_y, facing_left,
                    output rom_address, in_sprite, frame_idx, anim_busy);
`else
    modport master (output frame_start, trigger, drawX, drawY, sprite_x, sprite_y,
                    input  rom_address, in_sprite, frame_idx, anim_busy);
    modport slave  (input  frame_start, trigger, drawX, drawY, sprite_x, sprite_y,
                    output rom_address, in_sprite, frame_idx, anim_busy);
`endif
endinterface

// File: rtl/kyo_hit_addr_gen.sv
// Kyo hit sprite address stage: beam -> sprite ROM address plus 4-frame hit animation sequencer.
// Optional horizontal mirroring via facing_left when KYO_HIT_MIRROR_EN is defined.
//
// state | meaning
// IDLE  | no animation; sprite drawn as frame 0
// PLAY  | stepping frames every TICKS_PER_FRAME frame_start pulses
// HOLD  | last frame held for HOLD_TICKS pulses, then back to IDLE
module kyo_hit_addr_gen #(
    parameter int FRAME_W         = 64,
    parameter int FRAME_H         = 64,
    parameter int NUM_FRAMES      = 4,
    parameter int TICKS_PER_FRAME = 6,
    parameter int HOLD_TICKS      = 12
) (
    input  logic              vga_clk,
    input  logic              reset,
    kyo_hit_addr_gen_if.slave bus
);
    localparam int AW   = 14;
    localparam int TMAX = (TICKS_PER_FRAME > HOLD_TICKS) ? TICKS_PER_FRAME : HOLD_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [AW-1:0] FRAME_WORDS = AW'(FRAME_W * FRAME_H);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [1:0]      frame_idx_q, frame_idx_d;
    logic            busy_q;
    logic [AW-1:0]   rom_address_q, rom_address_d;
    logic            in_sprite_q, in_sprite_d;

    logic [10:0]     lx, ly, col, x_end, y_end;
    logic            hit;

    // 11-bit compares so a box hanging off the right/bottom edge clips instead of wrapping
    always_comb begin
        x_end = {1'b0, bus.sprite_x} + 11'(FRAME_W);
        y_end = {1'b0, bus.sprite_y} + 11'(FRAME_H);
        lx    = {1'b0, bus.drawX} - {1'b0, bus.sprite_x};
        ly    = {1'b0, bus.drawY} - {1'b0, bus.sprite_y};
        hit   = (bus.drawX >= bus.sprite_x) && ({1'b0, bus.drawX} < x_end) &&
                (bus.drawY >= bus.sprite_y) && ({1'b0, bus.drawY} < y_end);
`ifdef KYO_HIT_MIRROR_EN
        col   = bus.facing_left ? (11'(FRAME_W - 1) - lx) : lx;
`else
        col   = lx;
`endif
        rom_address_d = '0;
        in_sprite_d   = 1'b0;
        if (hit) begin
            rom_address_d = AW'(frame_idx_q) * FRAME_WORDS + AW'(ly) * AW'(FRAME_W) + AW'(col);
            in_sprite_d   = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        frame_idx_d = frame_idx_q;
        // trigger restarts from any state and swallows a coincident tick
        if (bus.trigger) begin
            state_d     = S_PLAY;
            tick_d      = '0;
            frame_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    frame_idx_d = '0;
                    tick_d      = '0;
                end
                S_PLAY: begin
                    if (bus.frame_start) begin
                        if (tick_q == TW'(TICKS_PER_FRAME - 1)) begin
                            tick_d = '0;
                            if (frame_idx_q == 2'(NUM_FRAMES - 1)) state_d = S_HOLD;
                            else                                  frame_idx_d = frame_idx_q + 2'd1;
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.frame_start) begin
                        if (tick_q == TW'(HOLD_TICKS - 1)) begin
                            state_d     = S_IDLE;
                            tick_d      = '0;
                            frame_idx_d = '0;
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    tick_d      = '0;
                    frame_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            frame_idx_q   <= '0;
            busy_q        <= 1'b0;
            rom_address_q <= '0;
            in_sprite_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            frame_idx_q   <= frame_idx_d;
            busy_q        <= (state_d != S_IDLE);
            rom_address_q <= rom_address_d;
            in_sprite_q   <= in_sprite_d;
        end
    end

    assign bus.rom_address = rom_address_q;
    assign bus.in_sprite   = in_sprite_q;
    assign bus.frame_idx   = frame_idx_q;
    assign bus.anim_busy   = busy_q;
endmodule

// File: tb/tb_kyo_hit_addr_gen.sv
// Bench for kyo_hit_addr_gen: directed scenarios plus random beam/animation traffic vs. a pulse-count model.
module tb_kyo_hit_addr_gen;
    localparam int FW = 64, FH = 64, NF = 4, TPF = 6, HOLD = 12;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    kyo_hit_addr_gen_if bus_if();

    kyo_hit_addr_gen dut (.vga_clk(vga_clk), .reset(reset), .bus(bus_if));

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: animation is just "pulses seen since the last trigger"
    bit m_active = 0;
    int m_pulses = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_frame();
        int f;
        if (!m_active) return 0;
        f = m_pulses / TPF;
        return (f > NF - 1) ? NF - 1 : f;
    endfunction

    task automatic step(input bit fs, input bit tr, input int dx, input int dy,
                        input int sx, input int sy, input bit fl);
        int  exp_addr, col;
        bit  exp_hit;
        @(negedge vga_clk);
        bus_if.frame_start = fs;
        bus_if.trigger     = tr;
        bus_if.drawX       = 10'(dx);
        bus_if.drawY       = 10'(dy);
        bus_if.sprite_x    = 10'(sx);
        bus_if.sprite_y    = 10'(sy);
`ifdef KYO_HIT_MIRROR_EN
        bus_if.facing_left = fl;
        col = fl ? (FW - 1 - (dx - sx)) : (dx - sx);
`else
        col = dx - sx + 0 * int'(fl);
`endif
        exp_hit  = (dx >= sx) && (dx < sx + FW) && (dy >= sy) && (dy < sy + FH);
        exp_addr = exp_hit ? (m_frame() * FW * FH + (dy - sy) * FW + col) : 0;
        if (tr) begin
            m_active = 1;
            m_pulses = 0;
        end else if (fs && m_active) begin
            m_pulses++;
            if (m_pulses == NF * TPF + HOLD) begin
                m_active = 0;
                m_pulses = 0;
            end
        end
        @(posedge vga_clk);
        #1;
        bus_if.frame_start = 1'b0;
        bus_if.trigger     = 1'b0;
        check("in_sprite",   int'(bus_if.in_sprite),   int'(exp_hit));
        check("rom_address", int'(bus_if.rom_address), exp_addr);
        check("frame_idx",   int'(bus_if.frame_idx),   m_frame());
        check("anim_busy",   int'(bus_if.anim_busy),   int'(m_active));
    endtask

    task automatic pulses(input int n, input int sx, input int sy);
        for (int i = 0; i < n; i++) step(1, 0, sx, sy, sx, sy, 0);
    endtask

    initial begin
        bus_if.frame_start = 0; bus_if.trigger = 0;
        bus_if.drawX = 0; bus_if.drawY = 0; bus_if.sprite_x = 0; bus_if.sprite_y = 0;
`ifdef KYO_HIT_MIRROR_EN
        bus_if.facing_left = 0;
`endif
        repeat (3) @(posedge vga_clk);
        #1;
        check("rst_addr",  int'(bus_if.rom_address), 0);
        check("rst_in",    int'(bus_if.in_sprite),   0);
        check("rst_frame", int'(bus_if.frame_idx),   0);
        check("rst_busy",  int'(bus_if.anim_busy),   0);
        @(negedge vga_clk);
        reset = 0;

        // T1 geometry in IDLE
        step(0, 0, 100, 50, 100, 50, 0);
        check("t1_origin", int'(bus_if.rom_address), 0);
        step(0, 0, 163, 113, 100, 50, 0);
        check("t1_corner", int'(bus_if.rom_address), 4095);
        step(0, 0, 164, 113, 100, 50, 0);
        check("t1_outside", int'(bus_if.in_sprite), 0);

        // T2 full animation
        step(0, 1, 100, 50, 100, 50, 0);
        pulses(6, 100, 50);
        step(0, 0, 100, 50, 100, 50, 0);
        check("t2_frame1_addr", int'(bus_if.rom_address), 4096);
        pulses(18, 100, 50);
        check("t2_hold_frame", int'(bus_if.frame_idx), 3);
        check("t2_hold_busy",  int'(bus_if.anim_busy), 1);
        pulses(11, 100, 50);
        check("t2_hold_busy11", int'(bus_if.anim_busy), 1);
        pulses(1, 100, 50);
        check("t2_idle_busy", int'(bus_if.anim_busy), 0);

        // T3 restart and trigger/frame_start collision
        step(0, 1, 0, 0, 100, 50, 0);
        pulses(12, 100, 50);
        check("t3_frame2", int'(bus_if.frame_idx), 2);
        step(0, 1, 0, 0, 100, 50, 0);
        check("t3_restart", int'(bus_if.frame_idx), 0);
        step(1, 1, 0, 0, 100, 50, 0);
        pulses(5, 100, 50);
        check("t3_tick_discard", int'(bus_if.frame_idx), 0);
        pulses(1, 100, 50);
        check("t3_advance", int'(bus_if.frame_idx), 1);

        // T4 async reset mid-play
        step(0, 1, 0, 0, 100, 50, 0);
        pulses(13, 100, 50);
        #2;
        reset = 1;
        #1;
        check("t4_addr",  int'(bus_if.rom_address), 0);
        check("t4_in",    int'(bus_if.in_sprite),   0);
        check("t4_frame", int'(bus_if.frame_idx),   0);
        check("t4_busy",  int'(bus_if.anim_busy),   0);
        m_active = 0;
        m_pulses = 0;
        @(negedge vga_clk);
        reset = 0;
        step(1, 0, 110, 60, 100, 50, 0);
        check("t4_resume", int'(bus_if.rom_address), 10 * 64 + 10);

`ifdef KYO_HIT_MIRROR_EN
        // T5 mirror
        step(0, 0, 100, 50, 100, 50, 1);
        check("t5_mirror_origin", int'(bus_if.rom_address), 63);
        step(0, 0, 163, 50, 100, 50, 1);
        check("t5_mirror_edge", int'(bus_if.rom_address), 0);
`endif

        // T6 right-edge clipping, no aliasing at drawX=0
        step(0, 0, 639, 0, 600, 0, 0);
        check("t6_edge", int'(bus_if.rom_address), 39);
        step(0, 0, 0, 0, 600, 0, 0);
        check("t6_alias", int'(bus_if.in_sprite), 0);

        // random traffic
        begin
            int sx = 0, sy = 0;
            for (int i = 0; i < 2500; i++) begin
                int dx, dy;
                if (i % 64 == 0) begin
                    sx = int'($urandom_range(0, 639));
                    sy = int'($urandom_range(0, 479));
                end
                if ($urandom_range(0, 3) != 0) begin
                    dx = sx + int'($urandom_range(0, 70)) - 3;
                    dy = sy + int'($urandom_range(0, 70)) - 3;
                    dx = (dx < 0) ? 0 : (dx > 639) ? 639 : dx;
                    dy = (dy < 0) ? 0 : (dy > 479) ? 479 : dy;
                end else begin
                    dx = int'($urandom_range(0, 639));
                    dy = int'($urandom_range(0, 479));
                end
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0),
                     dx, dy, sx, sy, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
